// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART byte transmitter
// between N_REQ byte producers. Grants one requester at a time, latches its
// byte, drives the start / brg_set / done handshake and pulses ack to the
// winner once the byte has left. Every output is registered.
//
// Ports:
//   clk_i           system clock, all logic on posedge
//   rst_ni          asynchronous active-low reset
//   req_i           req_i[i]=1: requester i has a byte pending (level)
//   data_i          byte of requester i on data_i[8i+7:8i]
//   grant_o         one-hot owner from START to SEND, else 0
//   ack_o           one-cycle pulse on ack_o[i]: byte of requester i sent
//   err_o           one-cycle pulse: SEND timed out waiting for uart_done_i
//   busy_o          1 in every state except IDLE
//   uart_data_o     latched byte, stable from START to SEND
//   uart_start_o    start request to the transmitter
//   uart_brg_set_i  transmitter accepted start
//   uart_done_i     transmitter finished the stop bit (pulse or level)
module uart_tx_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [8*N_REQ-1:0] data_i,
   output logic [N_REQ-1:0]   grant_o,
   output logic [N_REQ-1:0]   ack_o,
   output logic               err_o,
   output logic               busy_o,
   output logic [7:0]         uart_data_o,
   output logic               uart_start_o,
   input  logic               uart_brg_set_i,
   input  logic               uart_done_i
);

   localparam int unsigned IdxW   = $clog2(N_REQ);
   localparam int unsigned CntMax = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [1:0] {StIdle, StStart, StSend, StGap} state_e;

   state_e           state_q;
   logic [IdxW-1:0]  ptr_q;
   logic [IdxW-1:0]  owner_q;
   logic [CntW-1:0]  cnt_q;
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] ack_q;
   logic             err_q;
   logic             busy_q;
   logic [7:0]       uart_data_q;
   logic             uart_start_q;

   // (base + off) mod N_REQ; both operands are below N_REQ so one subtract suffices.
   function automatic logic [IdxW-1:0] rot_idx(logic [IdxW-1:0] base, int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return IdxW'(sum);
   endfunction

   // Round-robin pick starting at ptr_q. Scanning from the far end lets the
   // nearest requester overwrite earlier candidates, so no loop break is needed.
   logic [IdxW-1:0] win_idx;
   logic            win_vld;
   logic [7:0]      win_data;

   always_comb begin
      win_idx = '0;
      win_vld = 1'b0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         if (req_i[rot_idx(ptr_q, unsigned'(k))]) begin
            win_idx = rot_idx(ptr_q, unsigned'(k));
            win_vld = 1'b1;
         end
      end
      win_data = data_i[32'(win_idx) * 8 +: 8];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         owner_q      <= '0;
         cnt_q        <= '0;
         grant_q      <= '0;
         ack_q        <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         uart_data_q  <= 8'h00;
         uart_start_q <= 1'b0;
      end else begin
         ack_q <= '0;
         err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (win_vld) begin
                  state_q      <= StStart;
                  owner_q      <= win_idx;
                  grant_q      <= N_REQ'(1) << win_idx;
                  uart_data_q  <= win_data;
                  uart_start_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            StStart: begin
               if (uart_brg_set_i) begin
                  state_q      <= StSend;
                  uart_start_q <= 1'b0;
                  cnt_q        <= '0;
               end
            end
            StSend: begin
               // done seen on the last allowed cycle still wins over the timeout
               if (uart_done_i) begin
                  ack_q   <= grant_q;
                  grant_q <= '0;
                  ptr_q   <= rot_idx(owner_q, 1);
                  cnt_q   <= '0;
                  if (GAP_CYCLES == 0) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StGap;
                  end
               end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  grant_q <= '0;
                  ptr_q   <= rot_idx(owner_q, 1);
                  cnt_q   <= '0;
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StGap: begin
               if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign ack_o        = ack_q;
   assign err_o        = err_q;
   assign busy_o       = busy_q;
   assign uart_data_o  = uart_data_q;
   assign uart_start_o = uart_start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes the predicted winner,
// byte and outcome of each transfer; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 4;
   localparam int TO  = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [8*N-1:0] data;
   logic         brg;
   logic         done;
   logic [N-1:0] grant;
   logic [N-1:0] ack;
   logic         err;
   logic         busy;
   logic [7:0]   udata;
   logic         ustart;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ      (N),
      .GAP_CYCLES (GAP),
      .TIMEOUT    (TO)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_i          (req),
      .data_i         (data),
      .grant_o        (grant),
      .ack_o          (ack),
      .err_o          (err),
      .busy_o         (busy),
      .uart_data_o    (udata),
      .uart_start_o   (ustart),
      .uart_brg_set_i (brg),
      .uart_done_i    (done)
   );

   typedef struct {
      int         idx;
      logic [7:0] data;
      bit         to;
      int         brg_delay;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   model_ptr = 0;
   bit   tight_gap = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   task automatic bail(string why);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait expired, DUT event never came", why);
      summary();
      $finish;
   endtask

   // Reference arbitration: first requester at or after the pointer, wrapping.
   function automatic int pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [8*N-1:0] rand_data();
      logic [8*N-1:0] v;
      for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [N-1:0] r, logic [8*N-1:0] dat, bit to, int d);
      exp_t e;
      int   w;
      req  = r;
      data = dat;
      w = pick(r, model_ptr);
      e.idx       = w;
      e.data      = dat[8*w +: 8];
      e.to        = to;
      e.brg_delay = d;
      exp_q.push_back(e);
      model_ptr = (w + 1) % N;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy) return;
         tick();
      end
      bail("idle_wait");
   endtask

   task automatic wait_start(bit chk_lat);
      int i;
      for (i = 0; i < 20; i++) begin
         if (ustart) break;
         tick();
      end
      if (i == 20) bail("start_wait");
      if (chk_lat) check("req_to_start_latency", i, 1);
   endtask

   // Disturb inputs the DUT must ignore while a transfer is in flight.
   task automatic jostle(bit held);
      if (!held && $urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 3) == 0) data = rand_data();
      brg = ($urandom_range(0, 6) == 0);
   endtask

   task automatic serve(bit to, int d, bit held, bit chk_lat);
      int i;
      bit seen;
      wait_start(chk_lat);
      repeat (d) begin
         if (!held && $urandom_range(0, 2) == 0) req = N'($urandom);
         if ($urandom_range(0, 2) == 0) data = rand_data();
         done = ($urandom_range(0, 4) == 0);
         tick();
      end
      done = 1'b0;
      brg  = 1'b1;
      tick();
      brg  = 1'b0;
      seen = 1'b0;
      if (to) begin
         for (i = 0; i < TO + 30; i++) begin
            if (err) begin
               seen = 1'b1;
               break;
            end
            jostle(held);
            tick();
         end
         brg = 1'b0;
         if (!held) req = '0;
         if (!seen) bail("err_wait");
      end else begin
         repeat ($urandom_range(0, 20)) begin
            jostle(held);
            tick();
         end
         brg  = 1'b0;
         done = 1'b1;
         for (i = 0; i < 5; i++) begin
            tick();
            if (ack != 0) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) bail("ack_wait");
         if (!held) req = '0;
         if ($urandom_range(0, 1) == 1) tick();
         done = 1'b0;
      end
   endtask

   // Monitor: one consistent view per cycle (outputs of the cycle, inputs
   // that the DUT samples at the end of it).
   exp_t cur;
   bit   in_flight = 1'b0;
   bit   data_ok, prev_start = 1'b0, prev_acc = 1'b0;
   int   cyc = 0, start_cyc, acc_cyc, done_cyc, ack_cyc = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_flight  = 1'b0;
         prev_start = 1'b0;
         prev_acc   = 1'b0;
      end else begin
         cyc++;
         check("grant_onehot0", $onehot0(grant), 1);
         if (ustart && !prev_start) begin
            if (exp_q.size() == 0) begin
               check("unexpected_start", ustart, 0);
            end else begin
               cur = exp_q.pop_front();
               check("grant_owner", grant, 1 << cur.idx);
               check("uart_data", udata, cur.data);
               if (tight_gap) check("gap_ack_to_start", cyc - ack_cyc, GAP + 1);
               tight_gap = 1'b0;
               in_flight = 1'b1;
               data_ok   = 1'b1;
               start_cyc = cyc;
               acc_cyc   = -1;
               done_cyc  = -1;
            end
         end
         if (in_flight && grant != 0 && udata !== cur.data) data_ok = 1'b0;
         if (prev_start && !ustart) check("start_drop_only_after_brg", prev_acc, 1);
         if (in_flight && ustart && brg) begin
            acc_cyc = cyc;
            check("start_hold_len", cyc - start_cyc, cur.brg_delay);
         end
         if (in_flight && grant != 0 && !ustart && done && done_cyc < 0) done_cyc = cyc;
         if (ack != 0 || err) begin
            if (!in_flight) begin
               check("unexpected_ack", ack, 0);
               check("unexpected_err", err, 0);
            end else begin
               check("err_flag", err, cur.to);
               check("ack_vec", ack, cur.to ? 0 : (1 << cur.idx));
               check("grant_released", grant, 0);
               check("uart_data_stable", data_ok, 1);
               if (cur.to) check("timeout_latency", cyc - acc_cyc, TO + 1);
               else        check("ack_latency", cyc - done_cyc, 1);
               ack_cyc   = cyc;
               in_flight = 1'b0;
            end
         end
         prev_acc   = ustart && brg;
         prev_start = ustart;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8*N-1:0] dat;
      bit             to;
      int             d;
      req   = '0;
      data  = '0;
      brg   = 1'b0;
      done  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_start", ustart, 0);
      check("rst_data", udata, 0);
      rst_n = 1'b1;
      tick();

      // Fairness with all requests held: expect 0,1,2,3,0,1,... and a fixed gap.
      issue(4'b1111, rand_data(), 1'b0, 1);
      for (int k = 0; k < 6; k++) begin
         serve(1'b0, 1, 1'b1, k == 0);
         if (k < 5) begin
            tight_gap = 1'b1;
            issue(4'b1111, rand_data(), 1'b0, 1);
         end else begin
            req = '0;
         end
      end

      // Single requester 1 with byte 0x35.
      wait_idle();
      dat = rand_data();
      dat[15:8] = 8'h35;
      issue(4'b0010, dat, 1'b0, 0);
      serve(1'b0, 0, 1'b0, 1'b1);

      // Randomized traffic, occasional timeouts.
      for (int t = 0; t < 30; t++) begin
         wait_idle();
         to = ($urandom_range(0, 7) == 0);
         d  = $urandom_range(0, 5);
         issue(N'($urandom_range(1, (1 << N) - 1)), rand_data(), to, d);
         serve(to, d, 1'b0, 1'b1);
      end

      // Forced timeout, then the following requester must win.
      wait_idle();
      issue(4'b1001, rand_data(), 1'b1, 1);
      serve(1'b1, 1, 1'b0, 1'b1);
      wait_idle();
      issue(4'b1111, rand_data(), 1'b0, 0);
      serve(1'b0, 0, 1'b0, 1'b1);

      // Long handshake: brg_set withheld for 50 cycles.
      wait_idle();
      issue(4'b0100, rand_data(), 1'b0, 50);
      serve(1'b0, 50, 1'b0, 1'b1);

      // Reset in the middle of SEND.
      wait_idle();
      issue(4'b0110, rand_data(), 1'b0, 2);
      wait_start(1'b1);
      repeat (2) tick();
      brg = 1'b1;
      tick();
      brg = 1'b0;
      repeat (5) tick();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_grant", grant, 0);
      check("midrst_ack", ack, 0);
      check("midrst_err", err, 0);
      check("midrst_busy", busy, 0);
      check("midrst_start", ustart, 0);
      check("midrst_data", udata, 0);
      exp_q.delete();
      model_ptr = 0;
      req  = '0;
      data = '0;
      tick();
      tick();
      rst_n = 1'b1;
      issue(4'b1111, rand_data(), 1'b0, 1);
      serve(1'b0, 1, 1'b0, 1'b1);

      wait_idle();
      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);
      check("nothing_in_flight", in_flight, 0);
      summary();
      $finish;
   end

endmodule
